// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: HEADER, OPCODE, A_HI, A_LO, B_HI, B_LO, CHK.
// Latches a command when its XOR checksum matches; flags mismatches and inter-byte timeouts.
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic        uart_clock,
  input  logic        uart_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd_opcode,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        cmd_valid,
  output logic        cmd_error,
  output logic        busy
);

  localparam int unsigned CNT_W = 24;

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_AHI, S_ALO, S_BHI, S_BLO, S_CHK
  } state_t;

  state_t            state;
  logic              rx_valid_d;
  logic [CNT_W-1:0]  tcnt;
  logic [7:0]        csum;
  logic [7:0]        sh_opc;
  logic [15:0]       sh_a;
  logic [15:0]       sh_b;
  logic              strobe_c;
  logic              timeout_c;

  // One byte per rising edge of rx_valid, however long it stays high.
  assign strobe_c  = rx_valid & ~rx_valid_d;
  assign timeout_c = (state != S_IDLE) && (tcnt == TIMEOUT_CYCLES - CNT_W'(1));

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      state      <= S_IDLE;
      rx_valid_d <= 1'b1;
      tcnt       <= '0;
      csum       <= '0;
      sh_opc     <= '0;
      sh_a       <= '0;
      sh_b       <= '0;
      cmd_opcode <= '0;
      op_a       <= '0;
      op_b       <= '0;
      cmd_valid  <= 1'b0;
      cmd_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      cmd_valid  <= 1'b0;
      cmd_error  <= 1'b0;

      if (state == S_IDLE || strobe_c) tcnt <= '0;
      else                             tcnt <= tcnt + CNT_W'(1);

      // A strobe in the same cycle as the timeout wins.
      if (timeout_c && !strobe_c) begin
        cmd_error <= 1'b1;
        busy      <= 1'b0;
        state     <= S_IDLE;
      end else if (strobe_c) begin
        case (state)
          S_IDLE: begin
            if (rx_data == HEADER) begin
              csum  <= '0;
              busy  <= 1'b1;
              state <= S_OPC;
            end
          end
          S_OPC: begin
            sh_opc <= rx_data;
            csum   <= rx_data;
            state  <= S_AHI;
          end
          S_AHI: begin
            sh_a[15:8] <= rx_data;
            csum       <= csum ^ rx_data;
            state      <= S_ALO;
          end
          S_ALO: begin
            sh_a[7:0] <= rx_data;
            csum      <= csum ^ rx_data;
            state     <= S_BHI;
          end
          S_BHI: begin
            sh_b[15:8] <= rx_data;
            csum       <= csum ^ rx_data;
            state      <= S_BLO;
          end
          S_BLO: begin
            sh_b[7:0] <= rx_data;
            csum      <= csum ^ rx_data;
            state     <= S_CHK;
          end
          S_CHK: begin
            if (rx_data == csum) begin
              cmd_opcode <= sh_opc;
              op_a       <= sh_a;
              op_b       <= sh_b;
              cmd_valid  <= 1'b1;
            end else begin
              cmd_error  <= 1'b1;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
